// File: rtl/ram_write_buffer.sv
// Posted-write buffer between the REU DMA RAM port and the SDRAM controller's 8-bit CPU port.
// Define RAM_WRITE_BUFFER_READ_FORWARD_EN to let reads that hit queued writes return without a drain.
module ram_write_buffer #(
  parameter int A_BITS     = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  up_req,
  output logic                  up_ack,
  input  logic                  up_we,
  input  logic [A_BITS-1:0]     up_a,
  input  logic [7:0]            up_d,
  output logic [7:0]            up_q,
  output logic                  dn_req,
  input  logic                  dn_ack,
  output logic                  dn_we,
  output logic [A_BITS-1:0]     dn_a,
  output logic [7:0]            dn_d,
  input  logic [7:0]            dn_q,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  logic [1:0]            state;
  logic [A_BITS-1:0]     fifo_a [DEPTH];
  logic [7:0]            fifo_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic       up_pend;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       dn_done;
  logic       rd_issue;
  logic       rd_done;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  assign up_pend    = up_req != up_ack;
  assign fifo_empty = level == '0;
  assign dn_done    = dn_ack == dn_req;
  // Fullness uses the registered level, so a same-cycle pop never frees a slot for a push.
  assign push       = up_pend & up_we & (level != FULL_LEVEL);
  assign pop        = (state == ST_WR_WAIT) & dn_done;
  assign rd_issue   = (state == ST_IDLE) & fifo_empty & up_pend & ~up_we & ~fwd_hit;
  assign rd_done    = (state == ST_RD_WAIT) & dn_done;
  assign idle       = fifo_empty & (state == ST_IDLE) & ~up_pend;

`ifdef RAM_WRITE_BUFFER_READ_FORWARD_EN
  // Scan oldest to newest so the last match (newest write) wins; the in-flight head is still queued.
  always_comb begin
    logic match_any;
    match_any = 1'b0;
    fwd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((DEPTH_LOG2 + 1)'(i) < level) &&
          (fifo_a[rd_ptr + DEPTH_LOG2'(i)] == up_a)) begin
        match_any = 1'b1;
        fwd_data  = fifo_d[rd_ptr + DEPTH_LOG2'(i)];
      end
    end
    fwd_hit = match_any & up_pend & ~up_we;
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_ack <= 1'b0;
      up_q   <= '0;
      dn_req <= 1'b0;
      dn_we  <= 1'b0;
      dn_a   <= '0;
      dn_d   <= '0;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= ST_IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        up_ack <= up_req;
      end else if (fwd_hit) begin
        up_q   <= fwd_data;
        up_ack <= up_req;
      end else if (rd_done) begin
        up_q   <= dn_q;
        up_ack <= up_req;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end

      // Queued writes always go first, so a read can never overtake a posted write.
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            dn_we  <= 1'b1;
            dn_a   <= fifo_a[rd_ptr];
            dn_d   <= fifo_d[rd_ptr];
            dn_req <= ~dn_req;
            state  <= ST_WR_WAIT;
          end else if (rd_issue) begin
            dn_we  <= 1'b0;
            dn_a   <= up_a;
            dn_req <= ~dn_req;
            state  <= ST_RD_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (dn_done) begin
            state <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (dn_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= up_a;
      fifo_d[wr_ptr] <= up_d;
    end
  end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Self-checking bench for ram_write_buffer: directed table, multi-cycle corner sequences and
// randomized traffic checked against an in-order memory reference model.
module tb_ram_write_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        up_req, up_ack, up_we;
  logic [23:0] up_a;
  logic [7:0]  up_d, up_q;
  logic        dn_req, dn_ack, dn_we;
  logic [23:0] dn_a;
  logic [7:0]  dn_d, dn_q;
  logic [3:0]  level;
  logic        idle;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_write_buffer #(.A_BITS(24), .DEPTH_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .up_req(up_req), .up_ack(up_ack), .up_we(up_we), .up_a(up_a), .up_d(up_d), .up_q(up_q),
    .dn_req(dn_req), .dn_ack(dn_ack), .dn_we(dn_we), .dn_a(dn_a), .dn_d(dn_d), .dn_q(dn_q),
    .level(level), .idle(idle)
  );

  // Downstream SDRAM port model: sparse memory, programmable latency, stall switch, commit log.
  logic [7:0]  mem [int];
  logic [32:0] dlog [$];
  int          dn_lat = 0;
  int          dn_cnt;
  bit          dn_hold = 1'b0;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h3E;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_ack <= 1'b0;
      dn_q   <= 8'h00;
      dn_cnt <= 0;
    end else if (dn_req != dn_ack && !dn_hold) begin
      if (dn_cnt >= dn_lat) begin
        if (dn_we) mem[int'(dn_a)] = dn_d;
        else       dn_q <= mem_rd(dn_a);
        dlog.push_back({dn_we, dn_a, dn_d});
        dn_ack <= dn_req;
        dn_cnt <= 0;
      end else begin
        dn_cnt <= dn_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic send(input bit we, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    up_we  = we;
    up_a   = a;
    up_d   = d;
    up_req = ~up_req;
  endtask

  task automatic wait_ack(input string nm, output int cyc);
    cyc = 0;
    while (up_ack !== up_req && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " ack"}, 33'(up_ack), 33'(up_req));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " idle"}, 33'(idle), 33'd1);
  endtask

  typedef struct {
    bit          we;
    logic [23:0] a;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t       vt [7];
  logic [7:0] rmem [16];

  initial begin
    int cyc, base, n;
    logic r;

    reset_n = 1'b0;
    up_req  = 1'b0;
    up_we   = 1'b0;
    up_a    = '0;
    up_d    = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst up_ack", 33'(up_ack), 33'd0);
    chk("rst dn_req", 33'(dn_req), 33'd0);
    chk("rst dn_we",  33'(dn_we),  33'd0);
    chk("rst dn_a",   33'(dn_a),   33'd0);
    chk("rst dn_d",   33'(dn_d),   33'd0);
    chk("rst up_q",   33'(up_q),   33'd0);
    chk("rst level",  33'(level),  33'd0);
    chk("rst idle",   33'(idle),   33'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write, downstream latency 5
    dn_lat = 5;
    send(1'b1, 24'h001234, 8'hA5);
    @(posedge clk); #1;
    chk("t1 ack 1cyc", 33'(up_ack), 33'(up_req));
    chk("t1 level 1",  33'(level),  33'd1);
    @(posedge clk); #1;
    chk("t1 dn_req", 33'(dn_req), 33'd1);
    chk("t1 dn_we",  33'(dn_we),  33'd1);
    chk("t1 dn_a",   33'(dn_a),   33'h001234);
    chk("t1 dn_d",   33'(dn_d),   33'hA5);
    n = 0;
    while (level != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t1 level 0", 33'(level), 33'd0);
    wait_idle("t1");
    chk("t1 committed", dlog[dlog.size()-1], {1'b1, 24'h001234, 8'hA5});

    // Table of directed transactions
    vt[0] = '{1'b1, 24'h000500, 8'h12, 0, 8'h00};
    vt[1] = '{1'b0, 24'h000500, 8'h00, 0, 8'h12};
    vt[2] = '{1'b1, 24'h000501, 8'hFE, 3, 8'h00};
    vt[3] = '{1'b1, 24'h000500, 8'h34, 1, 8'h00};
    vt[4] = '{1'b0, 24'h000500, 8'h00, 2, 8'h34};
    vt[5] = '{1'b0, 24'h000501, 8'h00, 0, 8'hFE};
    vt[6] = '{1'b0, 24'h000502, 8'h00, 1, 8'h39};
    for (int i = 0; i < 7; i++) begin
      dn_lat = vt[i].lat;
      send(vt[i].we, vt[i].a, vt[i].d);
      wait_ack($sformatf("vec%0d", i), cyc);
      if (vt[i].we) chk($sformatf("vec%0d wr latency", i), 33'(cyc), 33'd1);
      else          chk($sformatf("vec%0d up_q", i), 33'(up_q), 33'(vt[i].exp_q));
    end
    wait_idle("vec");

    // Nine writes into a stalled downstream: the ninth waits for a slot
    dn_hold = 1'b1;
    dn_lat  = 0;
    base    = dlog.size();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 24'(i), 8'(8'h80 + i));
      wait_ack($sformatf("t2 wr%0d", i), cyc);
      chk($sformatf("t2 wr%0d latency", i), 33'(cyc), 33'd1);
    end
    chk("t2 level full", 33'(level), 33'd8);
    send(1'b1, 24'h000008, 8'h88);
    repeat (4) begin @(posedge clk); #1; end
    chk("t2 ninth held", 33'(up_ack == up_req), 33'd0);
    chk("t2 level still 8", 33'(level), 33'd8);
    dn_hold = 1'b0;
    n = 0;
    while (level != 7 && n < 50) begin @(posedge clk); #1; n++; end
    dn_hold = 1'b1;
    chk("t2 level 7", 33'(level), 33'd7);
    chk("t2 ninth still held", 33'(up_ack == up_req), 33'd0);
    @(posedge clk); #1;
    chk("t2 ninth acked", 33'(up_ack), 33'(up_req));
    chk("t2 level back 8", 33'(level), 33'd8);
    dn_hold = 1'b0;
    wait_idle("t2");
    chk("t2 commit count", 33'(dlog.size()), 33'(base + 9));
    for (int i = 0; i < 9; i++)
      chk($sformatf("t2 order%0d", i), dlog[base+i], {1'b1, 24'(i), 8'(8'h80 + i)});

    // Read queued behind a write
    dn_lat = 2;
    base   = dlog.size();
    send(1'b1, 24'h000100, 8'h55);
    wait_ack("t3 wr", cyc);
    send(1'b0, 24'h000200, 8'h00);
    wait_ack("t3 rd", cyc);
    chk("t3 up_q", 33'(up_q), 33'h3C);
    chk("t3 log size at read ack", 33'(dlog.size()), 33'(base + 2));
    chk("t3 write first", dlog[base], {1'b1, 24'h000100, 8'h55});
    chk("t3 read second", 33'(dlog[base+1][32:8]), {8'h00, 1'b0, 24'h000200});
    wait_idle("t3");

    // Asynchronous reset while a write is in flight with 3 queued
    dn_hold = 1'b1;
    dn_lat  = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 24'(24'h000600 + i), 8'(i));
      wait_ack($sformatf("t4 wr%0d", i), cyc);
    end
    @(posedge clk); #1;
    chk("t4 in flight", 33'(dn_req != dn_ack), 33'd1);
    chk("t4 level 3", 33'(level), 33'd3);
    @(negedge clk); #2;
    reset_n = 1'b0;
    up_req  = 1'b0;
    #1;
    chk("t4 level", 33'(level), 33'd0);
    chk("t4 dn_req", 33'(dn_req), 33'd0);
    chk("t4 up_ack", 33'(up_ack), 33'd0);
    chk("t4 idle", 33'(idle), 33'd1);
    base = dlog.size();
    @(negedge clk);
    reset_n = 1'b1;
    dn_hold = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("t4 no dn_req after release", 33'(dn_req), 33'd0);
    chk("t4 nothing committed", 33'(dlog.size()), 33'(base));

    // Read of an address with two queued writes
    dn_hold = 1'b1;
    base    = dlog.size();
    send(1'b1, 24'h000040, 8'h11);
    wait_ack("t5 wr11", cyc);
    send(1'b1, 24'h000040, 8'h22);
    wait_ack("t5 wr22", cyc);
    r = dn_req;
    send(1'b0, 24'h000040, 8'h00);
`ifdef RAM_WRITE_BUFFER_READ_FORWARD_EN
    @(posedge clk); #1;
    chk("t5 fwd ack 1cyc", 33'(up_ack), 33'(up_req));
    chk("t5 fwd up_q", 33'(up_q), 33'h22);
    chk("t5 no dn_req toggle", 33'(dn_req), 33'(r));
    dn_hold = 1'b0;
    wait_idle("t5");
    chk("t5 commits", 33'(dlog.size()), 33'(base + 2));
`else
    repeat (6) begin @(posedge clk); #1; end
    chk("t5 read held", 33'(up_ack == up_req), 33'd0);
    chk("t5 dn_req unchanged", 33'(dn_req), 33'(r));
    dn_hold = 1'b0;
    wait_ack("t5 rd", cyc);
    chk("t5 up_q", 33'(up_q), 33'h22);
    chk("t5 commits", 33'(dlog.size()), 33'(base + 3));
    chk("t5 wr11 first", dlog[base], {1'b1, 24'h000040, 8'h11});
    chk("t5 wr22 second", dlog[base+1], {1'b1, 24'h000040, 8'h22});
    chk("t5 read last", 33'(dlog[base+2][32]), 33'd0);
    wait_idle("t5");
`endif

    // Randomized traffic against an in-order memory model
    for (int i = 0; i < 16; i++) rmem[i] = 8'(i) ^ 8'h03 ^ 8'h3E;
    for (int k = 0; k < 200; k++) begin
      bit          we;
      int          idx;
      logic [7:0]  d;
      we     = 1'($urandom_range(0, 1));
      idx    = int'($urandom_range(0, 15));
      d      = 8'($urandom);
      dn_lat = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      send(we, 24'(24'h000300 + idx), d);
      wait_ack($sformatf("rnd%0d", k), cyc);
      if (we) rmem[idx] = d;
      else    chk($sformatf("rnd%0d read 0x%0h", k, 24'h000300 + idx), 33'(up_q), 33'(rmem[idx]));
    end
    wait_idle("rnd");
    for (int i = 0; i < 16; i++)
      chk($sformatf("rnd final mem%0d", i), 33'(mem_rd(24'(24'h000300 + i))), 33'(rmem[i]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
